// File: rtl/output_channel_fifo_if.sv
// rtl/output_channel_fifo_if.sv - byte stream and status bundle between input stage, output FIFO and consumer
interface output_channel_fifo_if #(
    parameter int DEPTH = 16
);
    logic [7:0]                   data_in;
    logic                         packet_valid_in;
    logic [7:0]                   channel;
    logic                         vld_chan;
    logic                         read_enb;
    logic                         err;
    logic                         suspend;
    logic                         overflow;
    logic                         timeout_flush;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;

    modport master (
        output data_in, packet_valid_in, read_enb,
        input  channel, vld_chan, err, suspend, overflow, timeout_flush, fifo_count
    );

    modport slave (
        input  data_in, packet_valid_in, read_enb,
        output channel, vld_chan, err, suspend, overflow, timeout_flush, fifo_count
    );
endinterface

// File: rtl/output_channel_fifo.sv
// rtl/output_channel_fifo.sv - per-channel FWFT output FIFO with parity check, back-pressure and stale flush
module output_channel_fifo #(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 2,
    parameter int TIMEOUT      = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    output_channel_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY} par_state_t;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [TW-1:0] idle_cnt;
    logic          empty;
    logic          full;
    logic          flush;
    logic          wr_en;
    logic          pop;
    logic          overflow_q;
    logic          suspend_q;
    logic          flush_q;

    par_state_t    state;
    logic [5:0]    remaining;
    logic [7:0]    acc;
    logic          err_q;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    // idle_cnt only climbs while non-empty and never drops count, so hitting TIMEOUT implies data to flush
    assign flush = (idle_cnt == TW'(TIMEOUT));
    assign wr_en = bus.packet_valid_in && !full && !flush;
    assign pop   = bus.read_enb && !empty && !flush;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (wr_en && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !wr_en)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            idle_cnt   <= '0;
            overflow_q <= 1'b0;
            suspend_q  <= 1'b0;
            flush_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
        end else begin
            count     <= count_nxt;
            flush_q   <= flush;
            suspend_q <= (int'(count_nxt) + AFULL_MARGIN) >= DEPTH;
            if (flush) begin
                rd_ptr   <= wr_ptr;
                idle_cnt <= '0;
            end else begin
                if (wr_en) begin
                    mem[wr_ptr] <= bus.data_in;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (bus.packet_valid_in && full)
                    overflow_q <= 1'b1;
                if (pop || empty)
                    idle_cnt <= '0;
                else
                    idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // Parity tracking sees every valid byte, including ones dropped by full or flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.packet_valid_in) begin
                case (state)
                    IDLE: begin
                        acc       <= bus.data_in;
                        remaining <= bus.data_in[7:2];
                        state     <= (bus.data_in[7:2] == 6'd0) ? PARITY : PAYLOAD;
                    end
                    PAYLOAD: begin
                        acc       <= acc ^ bus.data_in;
                        remaining <= remaining - 1'b1;
                        if (remaining == 6'd1)
                            state <= PARITY;
                    end
                    PARITY: begin
                        err_q <= ((acc ^ bus.data_in) != 8'h00);
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.channel       = mem[rd_ptr];
    assign bus.vld_chan      = !empty;
    assign bus.fifo_count    = count;
    assign bus.err           = err_q;
    assign bus.suspend       = suspend_q;
    assign bus.overflow      = overflow_q;
    assign bus.timeout_flush = flush_q;
endmodule

// File: tb/tb_output_channel_fifo.sv
// tb/tb_output_channel_fifo.sv - directed and random checks of output_channel_fifo against a queue model
module tb_output_channel_fifo;
    localparam int DEPTH   = 16;
    localparam int AFULL   = 2;
    localparam int TIMEOUT = 30;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    output_channel_fifo_if #(.DEPTH(DEPTH)) bus ();

    output_channel_fifo #(
        .DEPTH(DEPTH), .AFULL_MARGIN(AFULL), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [7:0] pkt[$];
    bit m_ovf, m_err, m_tf, m_susp;
    int m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        pkt.delete();
        m_ovf = 0; m_err = 0; m_tf = 0; m_susp = 0; m_idle = 0;
    endtask

    // Packet = header + (header>>2) payload bytes + parity byte; XOR of all must be zero
    task automatic model_edge(input bit v, input logic [7:0] d, input bit rd);
        bit vld, flush, full, pop;
        logic [7:0] x;
        vld   = (q.size() != 0);
        flush = vld && (m_idle >= TIMEOUT);
        m_err = 0;
        if (v) begin
            pkt.push_back(d);
            if (pkt.size() == int'(pkt[0][7:2]) + 2) begin
                x = 8'h00;
                foreach (pkt[i]) x ^= pkt[i];
                m_err = (x != 8'h00);
                pkt.delete();
            end
        end
        m_tf = flush;
        if (flush) begin
            q.delete();
            m_idle = 0;
        end else begin
            full = (q.size() == DEPTH);
            pop  = rd && vld;
            if (v && full) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (v && !full) q.push_back(d);
            m_idle = (pop || !vld) ? 0 : m_idle + 1;
        end
        m_susp = (DEPTH - q.size()) <= AFULL;
    endtask

    task automatic compare_all();
        chk("vld_chan", bus.vld_chan, q.size() != 0);
        chk("fifo_count", bus.fifo_count, q.size());
        if (q.size() != 0) chk("channel", bus.channel, q[0]);
        chk("err", bus.err, m_err);
        chk("suspend", bus.suspend, m_susp);
        chk("overflow", bus.overflow, m_ovf);
        chk("timeout_flush", bus.timeout_flush, m_tf);
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit rd);
        @(negedge clock);
        bus.packet_valid_in = v;
        bus.data_in         = d;
        bus.read_enb        = rd;
        model_edge(v, d, rd);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_channel"}, bus.channel, 0);
        chk({tag, "_vld"}, bus.vld_chan, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_suspend"}, bus.suspend, 0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_tflush"}, bus.timeout_flush, 0);
        chk({tag, "_count"}, bus.fifo_count, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        bus.packet_valid_in = 1'b0;
        bus.read_enb        = 1'b0;
        bus.data_in         = 8'h00;
        #1;
        check_zero(tag);
        model_clear();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        int n;
        bit seen;
        bit any_tf;
        int rd_pct;

        bus.packet_valid_in = 1'b0;
        bus.read_enb        = 1'b0;
        bus.data_in         = 8'h00;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // single good packet, then ordered readout
        step(1, 8'h08, 0); step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h3B, 0);
        chk("pkt_err", bus.err, 0);
        step(0, 8'h00, 0);
        chk("pkt_count", bus.fifo_count, 4);
        chk("pkt_vld", bus.vld_chan, 1);
        chk("pkt_head", bus.channel, 8'h08);
        exp_seq[0] = 8'h08; exp_seq[1] = 8'h11; exp_seq[2] = 8'h22; exp_seq[3] = 8'h3B;
        for (int i = 0; i < 4; i++) begin
            chk("pkt_read", bus.channel, exp_seq[i]);
            step(0, 8'h00, 1);
        end
        chk("pkt_empty", bus.vld_chan, 0);

        // bad parity
        step(1, 8'h04, 0); step(1, 8'hAA, 0); step(1, 8'h00, 0);
        chk("bad_err", bus.err, 1);
        chk("bad_count", bus.fifo_count, 3);
        step(0, 8'h00, 0);
        chk("bad_err_pulse", bus.err, 0);
        repeat (3) step(0, 8'h00, 1);

        // concurrent read/write at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) step(1, 8'h80 + 8'(i), 0);
        for (int k = 0; k < 20; k++) begin
            step(1, 8'h88 + 8'(k), 1);
            chk("conc_count", bus.fifo_count, 8);
            chk("conc_suspend", bus.suspend, 0);
        end
        chk("conc_head", bus.channel, 8'h94);
        repeat (8) step(0, 8'h00, 1);

        // timeout flush, with a write landing on the flush edge
        repeat (3) step(1, 8'h01, 0);
        n = 0; seen = 0;
        while (!seen && n < 60) begin
            n++;
            step(n == 29, 8'h5A, 0);
            if (bus.timeout_flush === 1'b1) seen = 1;
        end
        chk("tmo_steps", n, 29);
        chk("tmo_count", bus.fifo_count, 0);
        chk("tmo_vld", bus.vld_chan, 0);
        chk("tmo_ovf", bus.overflow, 0);
        step(0, 8'h00, 0);
        chk("tmo_pulse", bus.timeout_flush, 0);

        // a pop just before expiry prevents the flush
        repeat (3) step(1, 8'h01, 0);
        repeat (26) step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        any_tf = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 8'h00, 0);
            any_tf |= (bus.timeout_flush === 1'b1);
        end
        chk("tmo_prevented", any_tf, 0);
        chk("tmo_kept", bus.fifo_count, 2);
        repeat (2) step(0, 8'h00, 1);

        // fill and overflow
        for (int i = 0; i < 17; i++) begin
            step(1, 8'h40 + 8'(i), 0);
            if (i + 1 == 13) chk("fill_susp13", bus.suspend, 0);
            if (i + 1 == 14) chk("fill_susp14", bus.suspend, 1);
        end
        chk("fill_count", bus.fifo_count, 16);
        chk("fill_ovf", bus.overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk("fill_read", bus.channel, 8'h40 + 8'(i));
            step(0, 8'h00, 1);
        end
        chk("fill_drained", bus.vld_chan, 0);
        chk("fill_ovf_sticky", bus.overflow, 1);

        // reset mid-payload, then a fresh minimal packet
        step(1, 8'h0C, 0); step(1, 8'h55, 0);
        do_reset("midrst");
        step(1, 8'h00, 0); step(1, 8'h00, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_count", bus.fifo_count, 2);
        repeat (2) step(0, 8'h00, 1);

        // randomized phases with differing consumer rates
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: rd_pct = 50;
                1: rd_pct = 10;
                2: rd_pct = 0;
                default: rd_pct = 90;
            endcase
            for (int c = 0; c < 500; c++) begin
                if (ph == 1 && c == 250) do_reset("rndrst");
                step($urandom_range(99) < 60,
                     ($urandom_range(1) != 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255)),
                     $urandom_range(99) < rd_pct);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
